// File: rtl/edge_pkg.sv
// Shared definitions for the tick/level edge link: FSM encoding and width helper.
package edge_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } state_e;

  // ceil(log2(v)), but never less than one bit so a counter always exists.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter that stops at zero and flags the zero count as expired.
module hold_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/tick_level_generator.sv
// Rebuilds a level from transition ticks, enforcing a minimum hold after each flip
// and queueing ticks that arrive during the hold.
module tick_level_generator
  import edge_pkg::*;
#(
  parameter int unsigned MIN_HOLD   = 4,
  parameter int unsigned PEND_W     = 4,
  parameter logic        INIT_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  output logic              level,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int unsigned       CntW     = clog2_min1(MIN_HOLD);
  localparam logic [CntW-1:0]   HoldLoad = CntW'(MIN_HOLD - 1);
  localparam logic [PEND_W-1:0] PendMax  = '1;

  state_e            state_q, state_d;
  logic              level_q;
  logic              busy_q;
  logic              overflow_q;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              flip;
  logic              drop;
  logic              expired;

  hold_timer #(
    .W(CntW)
  ) u_hold_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (flip),
    .load_val(HoldLoad),
    .expired (expired)
  );

  always_comb begin
    flip      = 1'b0;
    drop      = 1'b0;
    pending_d = pending_q;
    state_d   = state_q;
    unique case (state_q)
      StIdle: begin
        flip    = tick;
        state_d = tick ? StHold : StIdle;
      end
      StHold: begin
        if (expired) begin
          flip = tick || (pending_q != '0);
          // One queued tick is consumed by this flip; a fresh tick replaces it.
          if (pending_q != '0) begin
            pending_d = pending_q - PEND_W'(1) + {{(PEND_W-1){1'b0}}, tick};
          end
          state_d = flip ? StHold : StIdle;
        end else if (tick) begin
          if (pending_q == PendMax) begin
            drop = 1'b1;
          end else begin
            pending_d = pending_q + PEND_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      level_q    <= INIT_LEVEL;
      pending_q  <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_q ^ flip;
      pending_q  <= pending_d;
      busy_q     <= (state_d == StHold);
      overflow_q <= drop;
    end
  end

  assign level    = level_q;
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: doc/tick_level_generator.md
# tick_level_generator

Rebuilds a level waveform from single-cycle transition ticks: each accepted tick flips the `level` output once. After every flip the block holds the level for a programmable minimum number of cycles, and it counts any ticks that arrive during the hold. It sits on the transmit side of a dual-edge link, driving a line that a downstream dual-edge detector turns back into one tick per transition. Tick count is preserved up to the pending-counter capacity; beyond that, ticks are dropped and flagged.

## Interface
- `MIN_HOLD`, default 4: minimum cycles `level` stays stable after a flip; legal range 1..255.
- `PEND_W`, default 4: width of the pending-tick counter; capacity is 2^PEND_W−1.
- `INIT_LEVEL`, default 0: value of `level` during and after reset.
- `clk`, in, 1: clock; all logic is on the rising edge.
- `reset`, in, 1: reset, asynchronous, active-high.
- `tick`, in, 1: one-cycle transition request; may be asserted on consecutive cycles.
- `level`, out, 1: registered reconstructed level.
- `busy`, out, 1: high while in HOLD.
- `pending`, out, PEND_W: number of queued, not-yet-applied ticks.
- `overflow`, out, 1: one-cycle pulse when a tick is dropped.

## Operation
- Reset values: `level`=INIT_LEVEL, state IDLE, `pending`=0, hold counter 0, `busy`=0, `overflow`=0.
- Reset mid-operation discards the queue. `level` returns to INIT_LEVEL asynchronously, with no hold enforced.
- The state machine is Moore-style with two states:
  - IDLE:
    - `pending` is always 0.
    - On `tick`: `level` flips at the next edge, the hold counter loads MIN_HOLD−1, and the state goes to HOLD.
    - With no tick, the state stays IDLE.
  - HOLD, with hold counter above 0:
    - The counter decrements each cycle.
    - On `tick`: `pending` increments if below 2^PEND_W−1.
    - If `pending` is already at that limit, the tick is dropped and `overflow` pulses next cycle.
  - HOLD, with hold counter equal to 0 (the "expire cycle"):
    - If `pending`>0 or `tick`: `level` flips, the counter reloads MIN_HOLD−1, and the state stays HOLD.
    - `pending` becomes pending − 1 + tick; the consumed and added ticks cancel, so the result never overflows.
    - Otherwise the state goes to IDLE.
- Arithmetic:
  - `pending` is unsigned and saturating, and never wraps.
  - The hold counter is ceil(log2(MIN_HOLD)) bits wide, minimum 1 bit.
- `busy` equals (state == HOLD), registered.

## Timing
- Latency from an idle tick at cycle n to the `level` flip visible at n+1 is 1 cycle.
- Minimum stable time after a flip: exactly MIN_HOLD cycles before the next flip can occur.
  - With MIN_HOLD=1, back-to-back flips every cycle are possible.
- A queued tick is applied at the flip following the expire cycle.
  - Steady-state throughput is one flip per MIN_HOLD cycles.
- `pending` and `overflow` update one cycle after the causing `tick`.
- `busy` rises together with the first `level` flip. It falls one cycle after an expire cycle that has no work.

## Structure
- Shared package `edge_pkg`:
  - State encoding: IDLE=1'b0, HOLD=1'b1.
  - Helper function `clog2_min1` for counter widths.
- Natural sub-module: `hold_timer`.
  - Loadable down-counter with `load`, `load_val`, and an `expired` (count==0) output.
  - Uses the same asynchronous reset.
- The top level holds the FSM, the pending counter, and the level register.

## Test plan
- Single tick. MIN_HOLD=4; reset, then tick at cycle 5:
  - `level` goes 0→1 at cycle 6.
  - `busy` is high for cycles 6–9.
  - The state is IDLE again with `busy`=0 at cycle 10.
  - `pending` stays 0 throughout.
- Queued ticks. MIN_HOLD=4; ticks at cycles 5, 6, 7:
  - `level` flips at cycles 6, 10, 14.
  - `pending` reads 1, 2 at cycles 7, 8, then 1 at 10 and 0 at 14.
  - `busy` falls at cycle 18.
- Overflow. MIN_HOLD=8, PEND_W=2; ticks at cycles 5–9:
  - `level` flips at cycle 6.
  - `pending` saturates at 3 by cycle 9.
  - `overflow` pulses at cycle 10 only.
  - Remaining flips occur at cycles 14, 22, 30.
- Tick on expire cycle. MIN_HOLD=4; tick at cycle 5, then tick at cycle 9 (expire cycle, `pending`=0):
  - `level` flips at 6 and 10.
  - `pending` stays 0 and `busy` stays high with no IDLE gap.
- Reset mid-operation. INIT_LEVEL=1, MIN_HOLD=4; ticks at 5, 6, 7, then reset asserted at cycle 8:
  - `level`=1, `pending`=0, `busy`=0 immediately.
  - No flips occur after reset is released.
- Minimum hold. MIN_HOLD=1; `tick` held high for cycles 5–12:
  - `level` toggles every cycle from 6 to 13.
  - `pending` stays 0 and `overflow` never fires.
